// File: rtl/mem_block_copier.sv
// mem_block_copier: bus initiator that copies a block of bytes between two
// regions of the 16-bit address space. It takes the bus from the arbiter with
// a request/grant handshake and moves one byte every two cycles: a read cycle
// that captures the combinational read data, then a write cycle.
module mem_block_copier #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_grant,
  output logic [15:0]      mem_address,
  output logic [7:0]       mem_data_out,
  input  logic [7:0]       mem_data_in,
  output logic             mem_chip_select,
  output logic             mem_wrt_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [15:0]      r_src;
  logic [15:0]      r_dst;
  logic [LEN_W-1:0] r_remaining;
  // Data register: holds the captured byte during WRITE and is cleared
  // whenever the write cycle ends, so it doubles as the mem_data_out driver.
  logic [7:0]       r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_bus_req;
  logic             r_cs;
  logic [15:0]      r_addr;

  logic             w_last_byte;
  logic             w_len_zero;

  assign w_last_byte = (r_remaining == LEN_W'(1));
  assign w_len_zero  = (length == {LEN_W{1'b0}});

  assign busy            = r_busy;
  assign done            = r_done;
  assign bus_req         = r_bus_req;
  assign mem_chip_select = r_cs;
  assign mem_address     = r_addr;
  assign mem_data_out    = r_data;
  // Reset gating stops a write at the very edge where reset lands mid-WRITE.
  assign mem_wrt_en      = (r_state == S_WRITE) && !reset;

  // Copy sequencer: state, pointers, count and the registered bus outputs,
  // each output loaded with the value it must show in the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_src       <= 16'd0;
      r_dst       <= 16'd0;
      r_remaining <= {LEN_W{1'b0}};
      r_data      <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_cs        <= 1'b0;
      r_addr      <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_len_zero) begin
              r_src       <= src_addr;
              r_dst       <= dst_addr;
              r_remaining <= length;
              r_busy      <= 1'b1;
              r_bus_req   <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              // Empty copy: report completion without touching the bus.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (bus_grant) begin
            r_cs    <= 1'b1;
            r_addr  <= r_src;
            r_state <= S_READ;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_READ: begin
          // Grant is not rechecked here: a started byte pair always finishes.
          r_data  <= mem_data_in;
          r_addr  <= r_dst;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_src       <= r_src + 16'd1;
          r_dst       <= r_dst + 16'd1;
          r_remaining <= r_remaining - LEN_W'(1);
          r_data      <= 8'd0;
          if (w_last_byte) begin
            r_busy    <= 1'b0;
            r_bus_req <= 1'b0;
            r_cs      <= 1'b0;
            r_addr    <= 16'd0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else if (bus_grant) begin
            r_addr  <= r_src + 16'd1;
            r_state <= S_READ;
          end else begin
            // Grant lost: park at the byte boundary and re-request.
            r_cs    <= 1'b0;
            r_addr  <= 16'd0;
            r_state <= S_REQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_bus_req <= 1'b0;
          r_cs      <= 1'b0;
          r_addr    <= 16'd0;
          r_data    <= 8'd0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: a 64 KiB memory with combinational read, a
// per-cycle grant schedule, and a reference model that predicts the final
// memory image and the completion cycle from the copy rules.
module tb_mem_block_copier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        bus_req;
  logic        bus_grant;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_chip_select;
  logic        mem_wrt_en;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] exp_mem [0:65535];
  bit         g       [0:1023];

  logic        pl_fill = 1'b0;
  logic [7:0]  pl_seed = 8'd0;
  logic        pl_we   = 1'b0;
  logic [15:0] pl_a    = 16'd0;
  logic [7:0]  pl_d    = 8'd0;

  always #5 clk = ~clk;

  mem_block_copier #(.LEN_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .bus_req         (bus_req),
    .bus_grant       (bus_grant),
    .mem_address     (mem_address),
    .mem_data_out    (mem_data_out),
    .mem_data_in     (mem_data_in),
    .mem_chip_select (mem_chip_select),
    .mem_wrt_en      (mem_wrt_en)
  );

  assign mem_data_in = mem[mem_address];

  // Memory: bulk fill, bench pokes, and DUT writes, all from one process.
  always @(posedge clk) begin
    if (pl_fill) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 7 + (i >> 8)) ^ pl_seed;
    end else if (pl_we) begin
      mem[pl_a] <= pl_d;
    end else if (mem_chip_select && mem_wrt_en) begin
      mem[mem_address] <= mem_data_out;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic fill_mem(input logic [7:0] seed);
    @(negedge clk);
    pl_seed = seed;
    pl_fill = 1'b1;
    @(posedge clk);
    #1 pl_fill = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic grant_all(input bit v);
    for (int i = 0; i < 1024; i++) g[i] = v;
  endtask

  // One transfer: model, drive, observe, compare. rst_cyc/sp_cyc < 0 disable
  // the mid-transfer reset and the ignored start pulse respectively.
  task automatic run_copy(input string name, input logic [15:0] s, input logic [15:0] d,
                          input int n, input int rst_cyc, input int sp_cyc,
                          output int got_done);
    int exp_done;
    int wcyc[$];
    int c, r, w, nexp_wr;
    int cyc, nwr, ncs, nreq, nboth, diffs;
    bit fin;
    logic [15:0] a_src, a_dst;

    // Timing model: REQ waits for grant, then READ, WRITE; grant sampled at
    // the end of each WRITE decides between another READ and a new REQ.
    exp_done = 1;
    if (n > 0) begin
      c = 1;
      while (!g[c] && c < 1000) c++;
      r = c + 1;
      for (int k = 0; k < n; k++) begin
        w = r + 1;
        wcyc.push_back(w);
        if (k == n - 1) exp_done = w + 1;
        else if (g[w]) r = w + 1;
        else begin
          c = w + 1;
          while (!g[c] && c < 1000) c++;
          r = c + 1;
        end
      end
    end

    // Data model: ascending byte-by-byte copy, 16-bit wrap, stops at reset.
    exp_mem = mem;
    nexp_wr = 0;
    for (int k = 0; k < n; k++) begin
      if (rst_cyc < 0 || wcyc[k] < rst_cyc) begin
        a_src = s + 16'(k);
        a_dst = d + 16'(k);
        exp_mem[a_dst] = exp_mem[a_src];
      end
      if (rst_cyc < 0 || wcyc[k] <= rst_cyc) nexp_wr++;
    end

    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    length    = 16'(n);
    start     = 1'b1;
    bus_grant = g[0];
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    bus_grant = g[1];
    got_done = -1;
    fin = 1'b0;
    nwr = 0; ncs = 0; nreq = 0; nboth = 0;

    while (!fin && cyc < 600) begin
      @(negedge clk);
      if (busy && done) nboth++;
      if (mem_wrt_en) nwr++;
      if (mem_chip_select) ncs++;
      if (bus_req) nreq++;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        check_val({name, "_rst_outs"},
                  {busy, done, bus_req, mem_chip_select, mem_wrt_en, mem_address, mem_data_out},
                  64'd0);
        fin = 1'b1;
      end else if (got_done >= 0) begin
        check_val({name, "_idle"}, {busy, done}, 64'd0);
        fin = 1'b1;
      end else if (done) begin
        got_done = cyc;
      end
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        #1 check_val({name, "_wr_gated"}, mem_wrt_en, 64'd0);
      end
      if (cyc == sp_cyc) begin
        start    = 1'b1;
        src_addr = 16'($urandom);
        dst_addr = 16'($urandom);
        length   = 16'($urandom_range(1, 9));
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      cyc++;
      bus_grant = g[cyc];
    end
    if (!fin) check_val({name, "_timeout"}, 64'd1, 64'd0);

    if (rst_cyc < 0) begin
      check_val({name, "_done_cyc"}, 64'(got_done), 64'(exp_done));
      check_val({name, "_ncs"}, 64'(ncs), 64'(2 * n));
      if (n == 0) check_val({name, "_nreq"}, 64'(nreq), 64'd0);
    end
    check_val({name, "_nwr"}, 64'(nwr), 64'(nexp_wr));
    check_val({name, "_overlap"}, 64'(nboth), 64'd0);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check_val({name, "_mem"}, 64'(diffs), 64'd0);
  endtask

  initial begin
    int dc;
    logic [15:0] rs, rd;
    int rn;

    reset = 1'b1; start = 1'b0; src_addr = 16'd0; dst_addr = 16'd0;
    length = 16'd0; bus_grant = 1'b0;
    fill_mem(8'h5A);
    @(negedge clk);
    check_val("reset_outs",
              {busy, done, bus_req, mem_chip_select, mem_wrt_en, mem_address, mem_data_out}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic 4-byte copy with grant held high.
    grant_all(1'b1);
    for (int i = 0; i < 4; i++) poke(16'h0200 + 16'(i), 8'h10 + 8'(i));
    run_copy("basic", 16'h0200, 16'h0300, 4, -1, -1, dc);
    check_val("basic_done10", 64'(dc), 64'd10);
    check_val("basic_b3", mem[16'h0303], 64'h13);

    // Zero length: immediate done, bus untouched.
    run_copy("len0", 16'h1234, 16'h4321, 0, -1, -1, dc);
    check_val("len0_done1", 64'(dc), 64'd1);

    // Source pointer wraps past 0xFFFF.
    run_copy("wrap", 16'hFFFE, 16'h1000, 3, -1, -1, dc);
    check_val("wrap_b2", mem[16'h1002], {56'd0, mem[16'h0000]});

    // Grant withdrawn for 3 cycles after the second WRITE.
    grant_all(1'b1);
    g[5] = 1'b0; g[6] = 1'b0; g[7] = 1'b0;
    run_copy("gdrop", 16'h0200, 16'h0400, 4, -1, -1, dc);
    check_val("gdrop_done13", 64'(dc), 64'd13);

    // Reset lands on the WRITE of byte 2, then a clean transfer follows.
    grant_all(1'b1);
    run_copy("rstmid", 16'h0200, 16'h0500, 4, 5, -1, dc);
    run_copy("after_rst", 16'h0200, 16'h0600, 4, -1, -1, dc);

    // Start pulsed mid-transfer with other parameters is ignored.
    run_copy("spulse", 16'h0200, 16'h0700, 4, -1, 4, dc);

    // Overlapping forward copy replicates the first byte.
    run_copy("ovl", 16'h0200, 16'h0201, 5, -1, -1, dc);

    // Randomized transfers with a random grant schedule.
    fill_mem(8'($urandom));
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 1024; i++) g[i] = ($urandom_range(0, 3) != 0);
      rs = 16'($urandom);
      rd = (t % 5 == 0) ? rs + 16'd1 : 16'($urandom);
      rn = $urandom_range(0, 24);
      run_copy("rand", rs, rd, rn, -1, (t % 3 == 0) ? 3 : -1, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_block_copier.md
# mem_block_copier

Bus initiator that copies a contiguous block of bytes from one region of the 64 KiB address space to another. It uses the same single-port memory interface the CPU uses: 16-bit address, 8-bit write data, 8-bit combinational read data, chip select and write enable. It sits beside the 6502 core and takes the memory bus through a request/grant handshake with the bus arbiter. Software and the bootloader use it for fast block moves while the CPU is held off the bus.

## Interface
Parameters:
- `LEN_W`, default 16: width of the transfer length and remaining-count register.

Ports:
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a transfer. Sampled only in IDLE.
- `src_addr`, input, 16: first source address. Latched on an accepted `start`.
- `dst_addr`, input, 16: first destination address. Latched on an accepted `start`.
- `length`, input, `LEN_W`: number of bytes to copy. Latched on an accepted `start`.
- `busy`, output, 1: high in REQ, READ and WRITE.
- `done`, output, 1: one-cycle pulse in DONE.
- `bus_req`, output, 1: request for the memory bus. High in REQ, READ and WRITE.
- `bus_grant`, input, 1: arbiter grant.
- `mem_address`, output, 16: address driven to memory.
- `mem_data_out`, output, 8: write data to the memory `data_in`.
- `mem_data_in`, input, 8: read data from the memory `data_out`. Combinational, valid in the same cycle the address is driven.
- `mem_chip_select`, output, 1: high in READ and WRITE.
- `mem_wrt_en`, output, 1: equals (state == WRITE) && !reset.

## Operation
States:
- IDLE:
  - `start`=1 with `length`≠0: latch `src_addr`, `dst_addr` and `length`, go to REQ.
  - `start`=1 with `length`=0: go to DONE without requesting the bus.
- REQ: wait for `bus_grant`=1, then go to READ.
- READ:
  - Drive `mem_address` = src pointer.
  - Capture `mem_data_in` into the data register at the clock edge.
  - Go to WRITE.
- WRITE:
  - Drive `mem_address` = dst pointer, `mem_data_out` = data register, `mem_wrt_en`=1. Memory writes at this edge.
  - At the edge: src += 1, dst += 1, remaining -= 1.
  - If remaining was 1, go to DONE.
  - Otherwise go to READ if `bus_grant`=1, else go to REQ.
- DONE: `done`=1 for one cycle, then go to IDLE.

Rules:
- `bus_grant` is checked only in REQ and at the end of WRITE. Dropping grant during READ does not abort the byte pair in progress; the copy pauses at the next byte boundary.
- Pointers are 16-bit and wrap from 16'hFFFF to 16'h0000 with no error.
- Overlapping regions are copied in ascending address order, with no overlap correction. With dst = src+1, the first byte is replicated across the block.
- `start` outside IDLE is ignored, including in DONE.
- Reset:
  - State goes to IDLE; pointers, remaining count and data register go to 0.
  - Reset values: `busy`=0, `done`=0, `bus_req`=0, `mem_chip_select`=0, `mem_wrt_en`=0, `mem_address`=0, `mem_data_out`=0.
  - The `!reset` gating on `mem_wrt_en` prevents a write at the edge where reset is asserted mid-WRITE.
  - Bytes already written stay written; the rest of the transfer is abandoned and is not resumed.
- Outside READ and WRITE, `mem_address` and `mem_data_out` hold 0.

## Timing
- `start` accepted at edge 0 gives REQ in cycle 1.
- With grant already high: first READ in cycle 2, first WRITE in cycle 3.
- Each byte takes 2 cycles. An N-byte copy with continuous grant has `done` high in cycle 2N+2 and returns to IDLE in cycle 2N+3.
- Each cycle of grant low in REQ adds one cycle.
- `length`=0: `done` high in cycle 1; `bus_req` never asserts.
- `busy` and `done` are never high in the same cycle.
- Read data is sampled at the end of READ; the memory's combinational read path must settle within one cycle.

## Test plan
- Memory preloaded with 0x10..0x13 at 0x0200; src=0x0200, dst=0x0300, length=4, grant tied high -> 0x0300..0x0303 = 0x10..0x13, `done` in cycle 10, exactly 4 cycles with `mem_wrt_en`=1, 0x0304 unchanged.
- length=0 -> `done` in cycle 1, `bus_req` never high, no memory access.
- length=3, src=0xFFFE, dst=0x1000 -> bytes from 0xFFFE, 0xFFFF, 0x0000 land at 0x1000..0x1002.
- length=4, grant dropped for 3 cycles after the second WRITE -> block returns to REQ, resumes at byte 3, data correct, `done` 3 cycles later than with continuous grant.
- Reset asserted during the WRITE of byte 2 of 4 -> byte 2 is not written, all outputs are 0 the next cycle, a new `start` then runs cleanly.
- `start` pulsed while busy with different addresses -> ignored; the original transfer completes unchanged.
